frame_store_ctrl: RTL and testbench

Capture sequencer for the camera frame buffer: sits between the RGB555 pixel unpacker and the frame BRAM. It arms on software/button request, aligns capture to sensor start-of-frame, and generates BRAM write address, data and enable. It ping-pongs two frame banks with the display reader, swapping only during display vertical blanking. It flags short and long frames.

---
 rtl/frame_store_ctrl.sv | 165 ++++++++++++++++
 tb/tb_frame_store_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_store_ctrl.sv
// frame_store_ctrl: capture sequencer between the RGB555 pixel unpacker and
// the frame BRAM. Arms on request, aligns to sensor start-of-frame, emits one
// BRAM write per accepted pixel and flags short/long frames.
// Optional feature: define FRAME_STORE_DOUBLE_BUF_EN for ping-pong banks that
// swap with the display reader only during display vertical blanking. Without
// it a single bank (0) is used and each frame completes as soon as it is full.
module frame_store_ctrl #(
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cap_start,
  input  logic              cap_cont,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              disp_vblank,
  input  logic              err_clr,
  output logic              mem_we,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              rd_bank,
  output logic              busy,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_long
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    CAPTURE   = 2'd2,
    SWAP_WAIT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] count;       // address of the next frame pixel
  logic [ADDR_W-1:0] count_next;
  logic [ADDR_W-1:0] wr_addr;     // address used by this cycle's write
  logic              wr_en;
  logic              swap;        // frame handed over to the display side
  logic              set_short;
  logic              set_long;

  // Next-state and per-cycle control decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    count_next = count;
    wr_addr    = count;
    wr_en      = 1'b0;
    swap       = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;

    case (state)
      IDLE: begin
        if (cap_start || cap_cont) state_next = ARMED;
      end

      ARMED: begin
        // Pixels before start-of-frame are dropped; a pixel coincident
        // with sof is frame pixel 0.
        if (sof) begin
          state_next = CAPTURE;
          wr_addr    = '0;
          count_next = '0;
          wr_en      = pix_valid;
        end
      end

      CAPTURE: begin
        // sof before the frame is full: restart at address 0, same bank.
        if (sof) begin
          set_short  = 1'b1;
          wr_addr    = '0;
          count_next = '0;
        end
        wr_en = pix_valid;
      end

      SWAP_WAIT: begin
`ifdef FRAME_STORE_DOUBLE_BUF_EN
        set_long = pix_valid;
        swap     = disp_vblank;
`else
        swap     = 1'b1;
`endif
        if (swap) state_next = cap_cont ? ARMED : IDLE;
      end

      default: state_next = IDLE;
    endcase

    // The count never goes past the last pixel; filling the frame parks it
    // at 0 and hands the frame over.
    if (wr_en) begin
      count_next = wr_addr + ONE;
      if (wr_addr == LAST_ADDR) begin
        count_next = '0;
        state_next = SWAP_WAIT;
      end
    end
  end

  // State, write port and sticky error registers.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments, so every register samples the
    // pre-edge values no matter how the statements are ordered.
    if (RESET) begin
      state      <= IDLE;
      count      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      mem_we     <= wr_en;
      frame_done <= swap;
      if (wr_en) begin
        mem_addr  <= wr_addr;
        mem_wdata <= pix_data;
      end
      // A set in the same cycle as a clear wins.
      if (set_short)    err_short <= 1'b1;
      else if (err_clr) err_short <= 1'b0;
      if (set_long)     err_long  <= 1'b1;
      else if (err_clr) err_long  <= 1'b0;
    end
  end

`ifdef FRAME_STORE_DOUBLE_BUF_EN
  // Ping-pong bank pointers: the display gets the bank just filled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_bank <= 1'b0;
      rd_bank  <= 1'b1;
    end else if (swap) begin
      rd_bank  <= mem_bank;
      mem_bank <= ~mem_bank;
    end
  end
`else
  // Single bank: writer and reader share bank 0, tearing is accepted.
  logic unused_vblank;
  assign unused_vblank = disp_vblank;
  assign mem_bank      = 1'b0;
  assign rd_bank       = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_frame_store_ctrl.sv
// tb_frame_store_ctrl: directed scenarios with random pixel data and gaps,
// checked every cycle against a frame-level reference model. Expectations
// follow whichever build of FRAME_STORE_DOUBLE_BUF_EN the design is given.
module tb_frame_store_ctrl;

  localparam int FP = 16;
  localparam int AW = 19;
  localparam int DW = 15;
`ifdef FRAME_STORE_DOUBLE_BUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic          cap_start, cap_cont, sof, pix_valid, disp_vblank, err_clr;
  logic [DW-1:0] pix_data;
  logic          mem_we, mem_bank, rd_bank, busy, frame_done, err_short, err_long;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  always #5 CLK = ~CLK;

  frame_store_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET), .cap_start(cap_start), .cap_cont(cap_cont),
    .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
    .disp_vblank(disp_vblank), .err_clr(err_clr), .mem_we(mem_we),
    .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_bank(rd_bank), .busy(busy), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: where the capture is in its frame life cycle.
  typedef enum int {P_IDLE, P_WAIT_SOF, P_FILL, P_FULL} phase_t;
  phase_t        m_phase;
  int            m_pos;       // pixels written in the current frame
  bit            m_bank, m_rd, m_short, m_long;
  bit            e_we, e_fd;
  int            e_addr;
  logic [DW-1:0] e_data;
  int            dut_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model over one rising edge using the current inputs.
  task automatic model_edge();
    bit accept   = 1'b0;
    bit short_ev = 1'b0;
    bit long_ev  = 1'b0;
    e_we = 1'b0;
    e_fd = 1'b0;
    if (RESET) begin
      m_phase = P_IDLE; m_pos = 0; m_bank = 1'b0; m_rd = DBUF;
      m_short = 1'b0; m_long = 1'b0;
      return;
    end
    case (m_phase)
      P_IDLE:     if (cap_start || cap_cont) m_phase = P_WAIT_SOF;
      P_WAIT_SOF: if (sof) begin m_phase = P_FILL; m_pos = 0; accept = pix_valid; end
      P_FILL: begin
        if (sof) begin short_ev = 1'b1; m_pos = 0; end
        accept = pix_valid;
      end
      P_FULL: begin
        long_ev = DBUF && pix_valid;
        if (!DBUF || disp_vblank) begin
          e_fd = 1'b1;
          if (DBUF) begin m_rd = m_bank; m_bank = !m_bank; end
          m_phase = cap_cont ? P_WAIT_SOF : P_IDLE;
        end
      end
      default: m_phase = P_IDLE;
    endcase
    if (accept) begin
      e_we   = 1'b1;
      e_addr = m_pos;
      e_data = pix_data;
      m_pos++;
      if (m_pos == FP) m_phase = P_FULL;
    end
    m_short = short_ev || (m_short && !err_clr);
    m_long  = long_ev  || (m_long  && !err_clr);
  endtask

  // One clock: update the model, then compare every output 1 time unit later.
  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    if (frame_done === 1'b1) dut_frames++;
    check("mem_we", 32'(mem_we), 32'(e_we));
    if (e_we) begin
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(e_data));
    end
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("mem_bank", 32'(mem_bank), 32'(m_bank));
    check("rd_bank", 32'(rd_bank), 32'(m_rd));
    check("busy", 32'(busy), 32'(m_phase != P_IDLE));
    check("err_short", 32'(err_short), 32'(m_short));
    check("err_long", 32'(err_long), 32'(m_long));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic arm();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
  endtask

  // Deliver n accepted pixels; optional sof on the first, optional random
  // gaps, data either 1..n or random.
  task automatic pixels(input int n, input bit with_sof, input bit gaps, input bit counting);
    int sent  = 0;
    bit first = with_sof;
    while (sent < n) begin
      sof       = first;
      pix_valid = first || !gaps || ($urandom_range(0, 3) != 0);
      pix_data  = counting ? DW'(sent + 1) : DW'($urandom);
      tick();
      if (pix_valid) sent++;
      first = 1'b0;
    end
    sof       = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int frames_before;
    RESET = 1'b1; cap_start = 1'b0; cap_cont = 1'b0; sof = 1'b0;
    pix_valid = 1'b0; pix_data = '0; disp_vblank = 1'b0; err_clr = 1'b0;
    idle(3);
    check("reset_mem_bank", 32'(mem_bank), 32'd0);
    check("reset_rd_bank", 32'(rd_bank), 32'(DBUF));
    check("reset_busy", 32'(busy), 32'd0);
    RESET = 1'b0;
    idle(2);

    // Single capture: pixels 1..16 contiguous, vblank already high.
    disp_vblank = 1'b1;
    arm();
    idle(1);
    pixels(FP, 1'b1, 1'b0, 1'b1);
    idle(3);
    check("single_frames", 32'(dut_frames), 32'd1);
    check("single_rd_bank", 32'(rd_bank), 32'd0);
    check("single_mem_bank", 32'(mem_bank), 32'(DBUF));
    check("single_busy", 32'(busy), 32'd0);

    // Pixels before sof are dropped; first write lands at address 0.
    arm();
    pixels(5, 1'b0, 1'b0, 1'b0);
    pixels(FP, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("prearm_frames", 32'(dut_frames), 32'd2);

    // Short frame, then clear; then set coincident with clear.
    arm();
    pixels(10, 1'b1, 1'b0, 1'b0);
    pixels(FP, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("short_set", 32'(err_short), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("short_clr", 32'(err_short), 32'd0);
    arm();
    pixels(4, 1'b1, 1'b0, 1'b0);
    sof = 1'b1; pix_valid = 1'b1; pix_data = DW'($urandom); err_clr = 1'b1;
    tick();
    sof = 1'b0; pix_valid = 1'b0; err_clr = 1'b0;
    check("short_set_wins", 32'(err_short), 32'd1);
    pixels(FP - 1, 1'b0, 1'b0, 1'b0);
    idle(2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Swap hold-off: vblank low for 20 cycles with 2 stray pixels.
    disp_vblank = 1'b0;
    frames_before = dut_frames;
    arm();
    pixels(FP, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      pix_valid = (i == 5) || (i == 12);
      pix_data  = DW'($urandom);
      tick();
    end
    pix_valid = 1'b0;
    check("holdoff_frames", 32'(dut_frames), 32'(frames_before + (DBUF ? 0 : 1)));
    check("holdoff_err_long", 32'(err_long), 32'(DBUF));
    disp_vblank = 1'b1;
    idle(2);
    check("holdoff_release", 32'(dut_frames), 32'(frames_before + 1));
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Continuous mode over three frames, cap_cont dropped mid frame 3.
    frames_before = dut_frames;
    cap_cont = 1'b1;
    idle(1);
    for (int f = 0; f < 2; f++) begin
      pixels(FP, 1'b1, 1'b1, 1'b0);
      idle(2);
    end
    pixels(FP / 2, 1'b1, 1'b0, 1'b0);
    cap_cont = 1'b0;
    pixels(FP / 2, 1'b0, 1'b1, 1'b0);
    idle(3);
    check("cont_frames", 32'(dut_frames), 32'(frames_before + 3));
    check("cont_busy", 32'(busy), 32'd0);

    // Reset mid-capture with err_short set.
    frames_before = dut_frames;
    arm();
    pixels(3, 1'b1, 1'b0, 1'b0);
    pixels(3, 1'b1, 1'b0, 1'b0);
    sof = 1'b0; pix_valid = 1'b1; pix_data = DW'($urandom); RESET = 1'b1;
    tick();
    RESET = 1'b0; pix_valid = 1'b0;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_bank", 32'(mem_bank), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'(DBUF));
    check("rst_err_short", 32'(err_short), 32'd0);
    idle(4);
    check("rst_no_done", 32'(dut_frames), 32'(frames_before));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
